// File: rtl/controle_tentativas.sv
// Attempt-sequencing FSM for the A/B PIN comparator: requires A then B to unlock,
// counts consecutive misses and holds a timed lockout after MAX_ERROS of them.
module controle_tentativas #(
  parameter int unsigned MAX_ERROS  = 3,
  parameter int unsigned T_BLOQUEIO = 50000000,
  parameter int unsigned T_LIBERADO = 100000000,
  parameter int unsigned W_ERR      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             confirmar,
  input  logic [1:0]       resultado,
  output logic             modoB,
  output logic             liberado,
  output logic             bloqueado,
  output logic             erro_pulso,
  output logic [W_ERR-1:0] num_erros,
  output logic [2:0]       estado
);

  localparam int unsigned T_MAX = (T_BLOQUEIO > T_LIBERADO) ? T_BLOQUEIO : T_LIBERADO;
  localparam int unsigned TW    = $clog2(T_MAX);

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] ESPERA_A = 3'd1;
  localparam logic [2:0] ESPERA_B = 3'd2;
  localparam logic [2:0] LIBERADO = 3'd3;
  localparam logic [2:0] BLOQUEIO = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [W_ERR-1:0] num_erros_q, num_erros_d;
  logic             erro_pulso_q, erro_pulso_d;
  logic             modoB_q, liberado_q, bloqueado_q;
  logic             hit;
  logic [W_ERR-1:0] erros_inc;

  // Next-state, error counter and timer
  always_comb begin
    state_d      = state_q;
    num_erros_d  = num_erros_q;
    erro_pulso_d = 1'b0;
    timer_d      = '0;
    hit          = (resultado == 2'b00);
    erros_inc    = (num_erros_q >= W_ERR'(MAX_ERROS)) ? num_erros_q
                                                       : num_erros_q + W_ERR'(1);
    case (state_q)
      OCIOSO: begin
        if (iniciar) begin
          state_d     = ESPERA_A;
          num_erros_d = '0;
        end
      end
      ESPERA_A, ESPERA_B: begin
        // confirmar takes priority over a simultaneous iniciar
        if (confirmar) begin
          if (hit) begin
            if (state_q == ESPERA_A) begin
              state_d = ESPERA_B;
            end else begin
              state_d     = LIBERADO;
              num_erros_d = '0;
            end
          end else begin
            erro_pulso_d = 1'b1;
            num_erros_d  = erros_inc;
            state_d      = (erros_inc == W_ERR'(MAX_ERROS)) ? BLOQUEIO : ESPERA_A;
          end
        end else if (iniciar) begin
          state_d = ESPERA_A;
        end
      end
      LIBERADO: begin
        if (iniciar) begin
          state_d = ESPERA_A;
        end else if (timer_q == TW'(T_LIBERADO - 1)) begin
          state_d = OCIOSO;
        end
      end
      BLOQUEIO: begin
        if (timer_q == TW'(T_BLOQUEIO - 1)) begin
          state_d     = OCIOSO;
          num_erros_d = '0;
        end
      end
      default: begin
        state_d     = OCIOSO;
        num_erros_d = '0;
      end
    endcase
    // Timer only runs while staying in a timed state; any transition clears it
    if ((state_d == state_q) && ((state_q == LIBERADO) || (state_q == BLOQUEIO))) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= OCIOSO;
      timer_q      <= '0;
      num_erros_q  <= '0;
      erro_pulso_q <= 1'b0;
      modoB_q      <= 1'b0;
      liberado_q   <= 1'b0;
      bloqueado_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      num_erros_q  <= num_erros_d;
      erro_pulso_q <= erro_pulso_d;
      modoB_q      <= (state_d == ESPERA_B);
      liberado_q   <= (state_d == LIBERADO);
      bloqueado_q  <= (state_d == BLOQUEIO);
    end
  end

  assign modoB      = modoB_q;
  assign liberado   = liberado_q;
  assign bloqueado  = bloqueado_q;
  assign erro_pulso = erro_pulso_q;
  assign num_erros  = num_erros_q;
  assign estado     = state_q;

endmodule
